// File: rtl/alu_pkg.sv
// Shared ALU definitions: the serial sequencer states and the bit positions of the NZCV flags.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } serial_state_t;

   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;
   localparam int FLAG_W = 4;

endpackage : alu_pkg

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
interface serial_adder_if #(
   parameter int M = 4
);
   logic         start;
   logic [M-1:0] A;
   logic [M-1:0] B;
   logic [M-1:0] R;
   logic         C;
   logic         N;
   logic         V;
   logic         Z;
   logic         busy;
   logic         done;

   modport master (
      output start, A, B,
      input  R, C, N, V, Z, busy, done
   );

   modport slave (
      input  start, A, B,
      output R, C, N, V, Z, busy, done
   );
endinterface : serial_adder_if

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared by the serial datapath across all bit positions.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic cin,
   output logic cout,
   output logic R
);
   assign R    = A ^ B ^ cin;
   assign cout = (A & B) | (A & cin) | (B & cin);
endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial M-bit two's-complement adder: one full_adder cell stepped LSB-first over M cycles,
// wrapped in a start/busy/done handshake, with NZCV flags loaded alongside the sum.
module serial_adder
   import alu_pkg::*;
#(
   parameter int M = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   serial_adder_if.slave bus
);

   localparam int                CNT_W    = (M > 1) ? $clog2(M) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(M - 1);

   serial_state_t       state_reg, state_next;

   logic [M-1:0]        shift_a_reg;
   logic [M-1:0]        shift_b_reg;
   logic [M-1:0]        sum_reg;
   logic                carry_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic                a_msb_reg;
   logic                b_msb_reg;

   logic [M-1:0]        r_reg;
   logic [FLAG_W-1:0]   flags_reg;

   logic                fa_sum;
   logic                fa_cout;
   logic                last_bit;
   logic [M-1:0]        sum_next;

   full_adder u_fa (
      .A    (shift_a_reg[0]),
      .B    (shift_b_reg[0]),
      .cin  (carry_reg),
      .cout (fa_cout),
      .R    (fa_sum)
   );

   assign last_bit = (cnt_reg == LAST_BIT);
   // Sum bits enter at the MSB so after M shifts bit 0 has reached position 0.
   assign sum_next = {fa_sum, sum_reg[M-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (last_bit)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_a_reg <= '0;
         shift_b_reg <= '0;
         sum_reg     <= '0;
         carry_reg   <= 1'b0;
         cnt_reg     <= '0;
         a_msb_reg   <= 1'b0;
         b_msb_reg   <= 1'b0;
         r_reg       <= '0;
         flags_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  shift_a_reg <= bus.A;
                  shift_b_reg <= bus.B;
                  a_msb_reg   <= bus.A[M-1];
                  b_msb_reg   <= bus.B[M-1];
                  sum_reg     <= '0;
                  carry_reg   <= 1'b0;
                  cnt_reg     <= '0;
               end
            end
            RUN: begin
               shift_a_reg <= {1'b0, shift_a_reg[M-1:1]};
               shift_b_reg <= {1'b0, shift_b_reg[M-1:1]};
               sum_reg     <= sum_next;
               carry_reg   <= fa_cout;
               if (last_bit) begin
                  r_reg             <= sum_next;
                  flags_reg[FLAG_N] <= fa_sum;
                  flags_reg[FLAG_Z] <= (sum_next == '0);
                  flags_reg[FLAG_C] <= fa_cout;
                  // Overflow judged from the operand MSBs captured at start, since the shifters have drained.
                  flags_reg[FLAG_V] <= (a_msb_reg == b_msb_reg) && (fa_sum != a_msb_reg);
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.R    = r_reg;
   assign bus.N    = flags_reg[FLAG_N];
   assign bus.Z    = flags_reg[FLAG_Z];
   assign bus.C    = flags_reg[FLAG_C];
   assign bus.V    = flags_reg[FLAG_V];
   assign bus.busy = (state_reg == RUN);
   assign bus.done = (state_reg == DONE);

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at M=4: sums, flag corners, handshake timing and mid-run reset.
module tb_serial_adder;

   localparam int M = 4;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   serial_adder_if #(.M(M)) bus ();

   serial_adder #(.M(M)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b,
                         input logic [M-1:0] exp_r, input logic ec, input logic en,
                         input logic ev, input logic ez);
      int  busy_cnt;
      int  lat;
      bit  got;
      busy_cnt = 0;
      lat      = 0;
      got      = 0;
      @(negedge clk);
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.A     = ~a;
      bus.B     = ~b;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_cnt++;
         if (bus.done) got = 1;
      end
      check("done_seen", 32'(got), 32'd1);
      check("latency", 32'(lat), 32'(M + 1));
      check("busy_cycles", 32'(busy_cnt), 32'(M));
      check("R", 32'(bus.R), 32'(exp_r));
      check("NZCV", {28'd0, bus.N, bus.Z, bus.C, bus.V}, {28'd0, en, ez, ec, ev});
      $display("op A=%b B=%b -> R=%b N=%b Z=%b C=%b V=%b busy=%0d",
               a, b, bus.R, bus.N, bus.Z, bus.C, bus.V, busy_cnt);
   endtask

   task automatic wait_done(output time t, output bit ok);
      ok = 0;
      t  = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.done) begin
            ok = 1;
            t  = $time;
         end
      end
   endtask

   initial begin
      time t1, t2, t3;
      bit  ok;
      int  done_cnt;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.A       = '0;
      bus.B       = '0;

      #2;
      check("rst_R", 32'(bus.R), 32'd0);
      check("rst_flags", {28'd0, bus.N, bus.Z, bus.C, bus.V}, 32'd0);
      check("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
      $display("reset R=%b busy=%b done=%b", bus.R, bus.busy, bus.done);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(4'd3,    4'd4,    4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op(4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0);
      run_op(4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      run_op(4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
      run_op(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op(4'b0101, 4'b1101, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);

      // Start held high: one result every M+2 cycles; A changed mid-run only affects the following op.
      @(negedge clk);
      bus.A     = 4'd2;
      bus.B     = 4'd2;
      bus.start = 1'b1;
      wait_done(t1, ok);
      check("hs_done1", 32'(ok), 32'd1);
      check("hs_R1", 32'(bus.R), 32'd4);
      $display("hold-start done1 t=%0t R=%b", t1, bus.R);
      @(negedge clk);
      @(negedge clk);
      check("hs_busy_run", 32'(bus.busy), 32'd1);
      bus.A = 4'd5;
      wait_done(t2, ok);
      check("hs_done2", 32'(ok), 32'd1);
      check("hs_period2", 32'(t2 - t1), 32'(10 * (M + 2)));
      check("hs_R2", 32'(bus.R), 32'd4);
      $display("hold-start done2 t=%0t R=%b", t2, bus.R);
      wait_done(t3, ok);
      check("hs_done3", 32'(ok), 32'd1);
      check("hs_period3", 32'(t3 - t2), 32'(10 * (M + 2)));
      check("hs_R3", 32'(bus.R), 32'd7);
      $display("hold-start done3 t=%0t R=%b", t3, bus.R);
      bus.start = 1'b0;

      // Asynchronous reset during the second RUN cycle.
      @(negedge clk);
      @(negedge clk);
      bus.A     = 4'd3;
      bus.B     = 4'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_R", 32'(bus.R), 32'd0);
      check("mid_rst_flags", {28'd0, bus.N, bus.Z, bus.C, bus.V}, 32'd0);
      check("mid_rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
      $display("mid-run reset R=%b busy=%b done=%b", bus.R, bus.busy, bus.done);
      @(negedge clk);
      rst_n    = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      check("no_done_after_rst", 32'(done_cnt), 32'd0);
      $display("post-reset idle done pulses=%0d", done_cnt);

      run_op(4'd1, 4'd1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial M-bit two's-complement adder, the additive counterpart of the combinational subtractor. It reuses one full_adder cell over M clock cycles instead of a ripple chain of M cells. A start/busy/done handshake wraps the operation, and the block reports an NZCV flag set with the same meaning as the subtractor's flags. It sits beside the subtractor in the ALU datapath for area-constrained builds.

Parameters:
M, 4, operand/result width in bits (M >= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request an addition; sampled only in IDLE
A  input  M  addend A; captured on the accepted start edge
B  input  M  addend B; captured on the accepted start edge
R  output  M  registered sum A+B mod 2^M
C  output  1  carry out of bit M-1
N  output  1  R[M-1]
V  output  1  signed overflow
Z  output  1  R == 0
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when R/flags update

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (asynchronous, any time including mid-RUN):
  - state to IDLE; operand shift registers, carry flop and bit counter to 0.
  - R=0, C=N=V=Z=0, busy=0, done=0.
  - Any operation in progress is abandoned with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture A and B into shift registers, clear carry flop (cin=0), clear counter, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), each edge:
  - full_adder input A = shiftA[0], input B = shiftB[0], cin = carry flop.
  - Sum bit shifts into the MSB of the sum shift register; shiftA and shiftB shift right; carry flop takes cout; counter increments.
  - On the edge where counter == M-1: go to DONE and load the output registers.
- Output register load (on the RUN-to-DONE edge):
  - R = completed sum.
  - C = final cout.
  - N = sum[M-1].
  - V = (A[M-1] == B[M-1]) && (sum[M-1] != A[M-1]), using the captured operand MSBs.
  - Z = (sum == 0). Z is independent of C.
- DONE: done=1 for exactly one cycle, busy=0, then unconditionally to IDLE. A start asserted during DONE is ignored.
- Latency:
  - Start accepted at edge k; done is high in the cycle after edge k+M.
  - Next start can be accepted at edge k+M+2, giving throughput of one operation per M+2 cycles.
- start while busy or in DONE is ignored; the in-flight operands are unaffected.
- A and B may change freely after the accepted start edge.
- R and flags hold their values between done pulses and are never glitched during RUN.
- Counter width is $clog2(M), sized so it cannot wrap before M-1.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t
  - flag index constants FLAG_N, FLAG_Z, FLAG_C, FLAG_V
- Sub-module: one instance of the existing full_adder (ports A, B, cin, cout, R). No other sub-modules are needed.

Test Plan (M=4):
1. Basic sum: A=3, B=4, start pulse -> after 4 RUN cycles, done=1 with R=0111, C=0, N=0, V=0, Z=0. busy is high for exactly 4 cycles.
2. Signed overflow: A=0111, B=0001 -> R=1000, N=1, V=1, C=0, Z=0.
3. Unsigned wrap: A=1111, B=0001 -> R=0000, C=1, Z=1, V=0, N=0.
4. Both overflows: A=1000, B=1000 -> R=0000, C=1, V=1, Z=1, N=0. Then A=0, B=0 -> Z=1, C=0.
5. Handshake:
   - Hold start high continuously with A=2, B=2 -> done pulses every 6 cycles with R=0100.
   - Change A to 5 during RUN -> the current result is still 0100.
6. Reset mid-operation: assert rst_n=0 during the 2nd RUN cycle -> outputs immediately 0, no done pulse. After release, start with A=1, B=1 -> R=0010.
